// File: rtl/alu.sv
// Registered N-bit ALU: add/sub, bitwise logic and shifts, with NZCV flags.
// Inputs are computed combinationally and captured into r/f on every rising edge.
module alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   uc,
  output logic [N-1:0] r,
  output logic [3:0]   f
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [N-1:0] WIDTH = N'(N);

  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] sll_res;
  logic [N-1:0] srl_res;
  logic [N-1:0] sra_res;
  logic         shl_c;
  logic         shr_c;
  logic         sra_c;
  logic         wide_shift;

  logic [N-1:0] r_nxt;
  logic         c_nxt;
  logic         v_nxt;

  // Bit N of the extended difference is the borrow out.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign sll_res    = a << b;
  assign srl_res    = a >> b;
  assign sra_res    = N'($signed(a) >>> b);
  assign wide_shift = (b > WIDTH);

  // Last bit shifted out: for a left shift by k it is a[N-k], for a right
  // shift by k it is a[k-1]; k outside 1..N leaves the carry at 0.
  always_comb begin
    shl_c = 1'b0;
    shr_c = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (b == N'(N - i)) shl_c = a[i];
      if (b == N'(i + 1)) shr_c = a[i];
    end
  end

  // Shifting an arithmetic value past its width keeps pushing the sign bit out.
  assign sra_c = wide_shift ? a[N-1] : shr_c;

  // NOTE: every output of this block gets a default first so that no path
  // through the case statement can leave a variable unassigned (no latches).
  always_comb begin
    r_nxt = '0;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (uc)
      OP_ADD: begin
        r_nxt = sum[N-1:0];
        c_nxt = sum[N];
        v_nxt = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        r_nxt = diff[N-1:0];
        c_nxt = ~diff[N];
        v_nxt = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND: r_nxt = a & b;
      OP_OR:  r_nxt = a | b;
      OP_XOR: r_nxt = a ^ b;
      OP_SLL: begin
        r_nxt = sll_res;
        c_nxt = shl_c;
      end
      OP_SRL: begin
        r_nxt = srl_res;
        c_nxt = shr_c;
      end
      OP_SRA: begin
        r_nxt = sra_res;
        c_nxt = sra_c;
      end
      default: begin
        r_nxt = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      f <= '0;
    end else begin
      r <= r_nxt;
      f <= {r_nxt[N-1], ~|r_nxt, c_nxt, v_nxt};
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU (N=4): reset, every opcode,
// shift boundary cases and one-cycle latency.
module tb_alu;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   uc;
  logic [N-1:0] r;
  logic [3:0]   f;

  int total = 0;
  int bad   = 0;

  alu #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .uc    (uc),
    .r     (r),
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Drive inputs between edges, then sample one time unit after the edge.
  task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                      input logic [2:0] tuc, input logic [3:0] er, input logic [3:0] ef);
    @(negedge clk);
    a  = ta;
    b  = tb_v;
    uc = tuc;
    @(posedge clk);
    #1;
    check({tag, " r"}, {4'b0, r}, {4'b0, er});
    check({tag, " f"}, {4'b0, f}, {4'b0, ef});
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    uc    = '0;
    #2;
    check("reset r", {4'b0, r}, 8'h00);
    check("reset f", {4'b0, f}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    step("first add", 4'b0111, 4'b0001, 3'b000, 4'b1000, 4'b1001);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    a  = 4'b0101;
    b  = 4'b0101;
    uc = 3'b011;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst r", {4'b0, r}, 8'h00);
    check("async rst f", {4'b0, f}, 8'h00);
    @(posedge clk);
    #1;
    check("rst hold r", {4'b0, r}, 8'h00);
    check("rst hold f", {4'b0, f}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step("post rst", 4'b0001, 4'b0001, 3'b000, 4'b0010, 4'b0000);

    // ADD
    step("add ovf",   4'b0111, 4'b0001, 3'b000, 4'b1000, 4'b1001);
    step("add carry", 4'b1111, 4'b0001, 3'b000, 4'b0000, 4'b0110);
    step("add zero",  4'b0000, 4'b0000, 3'b000, 4'b0000, 4'b0100);

    // SUB
    step("sub eq",     4'b0001, 4'b0001, 3'b001, 4'b0000, 4'b0110);
    step("sub borrow", 4'b0000, 4'b0001, 3'b001, 4'b1111, 4'b1000);
    step("sub ovf",    4'b1000, 4'b0001, 3'b001, 4'b0111, 4'b0011);

    // Logic
    step("and", 4'b0001, 4'b0001, 3'b010, 4'b0001, 4'b0000);
    step("or",  4'b0001, 4'b0001, 3'b011, 4'b0001, 4'b0000);
    step("xor", 4'b0001, 4'b0001, 3'b100, 4'b0000, 4'b0100);
    step("and mix", 4'b1100, 4'b1010, 3'b010, 4'b1000, 4'b1000);

    // Shifts
    step("sll 1",      4'b0001, 4'b0001, 3'b101, 4'b0010, 4'b0000);
    step("srl 1",      4'b0001, 4'b0001, 3'b110, 4'b0000, 4'b0110);
    step("sra 1",      4'b1000, 4'b0001, 3'b111, 4'b1100, 4'b1000);
    step("sll 5",      4'b0001, 4'b0101, 3'b101, 4'b0000, 4'b0100);
    step("sra 6",      4'b1000, 4'b0110, 3'b111, 4'b1111, 4'b1010);
    step("sll c out",  4'b1001, 4'b0001, 3'b101, 4'b0010, 4'b0010);
    step("sll by N",   4'b0011, 4'b0100, 3'b101, 4'b0000, 4'b0110);
    step("srl by N",   4'b1000, 4'b0100, 3'b110, 4'b0000, 4'b0110);
    step("srl by 0",   4'b1010, 4'b0000, 3'b110, 4'b1010, 4'b1000);
    step("sra pos 7",  4'b0100, 4'b0111, 3'b111, 4'b0000, 4'b0100);
    step("srl wide",   4'b1111, 4'b1111, 3'b110, 4'b0000, 4'b0100);

    // Latency sweep: each result reflects the previous cycle's inputs, and
    // input changes between edges leave r/f untouched.
    step("lat add", 4'b0001, 4'b0001, 3'b000, 4'b0010, 4'b0000);
    @(negedge clk);
    a  = 4'b1111;
    b  = 4'b1111;
    uc = 3'b011;
    #2;
    check("hold r", {4'b0, r}, 8'h02);
    check("hold f", {4'b0, f}, 8'h00);
    step("lat sub", 4'b0001, 4'b0001, 3'b001, 4'b0000, 4'b0110);
    step("lat and", 4'b0001, 4'b0001, 3'b010, 4'b0001, 4'b0000);
    step("lat or",  4'b0001, 4'b0001, 3'b011, 4'b0001, 4'b0000);
    step("lat xor", 4'b0001, 4'b0001, 3'b100, 4'b0000, 4'b0100);
    step("lat sll", 4'b0001, 4'b0001, 3'b101, 4'b0010, 4'b0000);
    step("lat srl", 4'b0001, 4'b0001, 3'b110, 4'b0000, 4'b0110);
    step("lat sra", 4'b0001, 4'b0001, 3'b111, 4'b0000, 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised N-bit registered ALU: two operands, 3-bit opcode, result plus 4 status flags.
- Operands and opcode are sampled on every rising clock edge.
- Result and flags are presented from output registers one cycle later.
- Serves as the arithmetic/logic execution unit of the lab datapath; driven directly by the control unit.

Parameters:
- N, 4, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  N  operand A.
- b  input  N  operand B; also the shift amount (unsigned) for shift ops.
- uc  input  3  operation select from control unit.
- r  output  N  registered result.
- f  output  4  registered flags: f[3]=N (negative), f[2]=Z (zero), f[1]=C (carry), f[0]=V (overflow).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low forces r=0 and f=0 immediately, independent of clk.
  - r and f hold 0 while rst_n is low.
  - First capture occurs on the first rising clk edge after rst_n deasserts.
  - Reset asserted mid-operation discards the pending result.
- Latency and update:
  - Next-state values are computed combinationally from a, b, uc.
  - They are loaded into r/f on every rising clk edge; latency is exactly 1 cycle.
  - No enable and no handshake; r/f update every cycle.
- Opcodes (uc):
  - 000 ADD: r = a + b mod 2^N. C = carry out of bit N-1. V = signed overflow (operands same sign, result sign differs).
  - 001 SUB: r = a - b mod 2^N. C = 1 when no borrow (a >= b unsigned). V = signed overflow (operands differ in sign, result sign differs from a).
  - 010 AND: r = a & b.
  - 011 OR: r = a | b.
  - 100 XOR: r = a ^ b.
  - 101 SLL: r = a << b, zero fill.
  - 110 SRL: r = a >> b, zero fill.
  - 111 SRA: r = a >>> b, sign fill from a[N-1].
- Shift rules:
  - Shift amount is the full unsigned value of b.
  - b >= N gives r=0 for SLL/SRL; for SRA, r = all bits equal to a[N-1].
  - C = last bit shifted out when 1 <= b <= N.
  - C = 0 when b = 0.
  - C = 0 when b > N for SLL/SRL; C = a[N-1] when b > N for SRA.
  - V = 0 for all shifts.
- Logic ops (AND/OR/XOR): C=0, V=0.
- All ops: N flag = r[N-1], Z flag = (r == 0). Both are computed from the next-state result.
- All 8 codes are defined; there are no illegal opcodes.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> r=0000, f=0000 immediately. After release with a=0001, b=0001, uc=000 -> next edge r=0010, f=0000.
- ADD: a=0111, b=0001 -> r=1000, f=1001. a=1111, b=0001 -> r=0000, f=0110. a=0000, b=0000 -> r=0000, f=0100.
- SUB: a=0001, b=0001 -> r=0000, f=0110. a=0000, b=0001 -> r=1111, f=1000. a=1000, b=0001 -> r=0111, f=0011.
- Logic: a=0001, b=0001 -> AND r=0001 f=0000; OR r=0001 f=0000; XOR r=0000 f=0100.
- Shifts:
  - SLL a=0001, b=0001 -> r=0010, f=0000.
  - SRL a=0001, b=0001 -> r=0000, f=0110.
  - SRA a=1000, b=0001 -> r=1100, f=1000.
  - SLL a=0001, b=0101 -> r=0000, f=0100.
  - SRA a=1000, b=0110 -> r=1111, f=1010.
- Latency: sweep uc 000..111 with a=b=0001, changing inputs each cycle -> each r/f reflects the previous cycle's inputs exactly. Changing inputs between edges does not alter r/f.
